// File: rtl/riscv_rtype_pkg.sv
// Shared constants, ALU operation enum and funct decoder for the R-type teaching core.
package riscv_rtype_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_NOP
  } alu_op_t;

  // Any funct7/funct3 pair outside the supported set collapses to NOP.
  function automatic alu_op_t decode_alu_op(input logic [6:0] f7, input logic [2:0] f3);
    alu_op_t op;
    op = ALU_NOP;
    if (f7 == F7_BASE) begin
      case (f3)
        F3_ADD_SUB: op = ALU_ADD;
        F3_SLL:     op = ALU_SLL;
        F3_SLT:     op = ALU_SLT;
        F3_SLTU:    op = ALU_SLTU;
        F3_XOR:     op = ALU_XOR;
        F3_SRL_SRA: op = ALU_SRL;
        F3_OR:      op = ALU_OR;
        F3_AND:     op = ALU_AND;
        default:    op = ALU_NOP;
      endcase
    end else if (f7 == F7_ALT) begin
      case (f3)
        F3_ADD_SUB: op = ALU_SUB;
        F3_SRL_SRA: op = ALU_SRA;
        default:    op = ALU_NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/riscv_rtype_if.sv
// Fetch bus carrying the current instruction word from the fetch stage to decode.
interface riscv_rtype_if;
  logic [31:0] instr;

  modport master (output instr);
  modport slave  (input  instr);
endinterface

// File: rtl/riscv_rtype_alu.sv
// Pure combinational ALU for the ten RV32I R-type operations.
module riscv_rtype_alu
  import riscv_rtype_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   y
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = XLEN'($signed(a) >>> shamt);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/riscv_rtype_id_stage.sv
// Decode stage: field extraction, ALU op selection and the 32-entry register file.
module riscv_rtype_reg_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] regfile [0:31];

  // Only the addressed entry is touched on a write, so external pokes elsewhere survive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regfile[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regfile[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regfile[rs2_addr];

endmodule

module riscv_rtype_id_stage
  import riscv_rtype_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  riscv_rtype_if.slave    fetch,
  input  logic [XLEN-1:0] wb_data,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       wb_en;

  assign opcode = fetch.instr[6:0];
  assign rd     = fetch.instr[11:7];
  assign funct3 = fetch.instr[14:12];
  assign rs1    = fetch.instr[19:15];
  assign rs2    = fetch.instr[24:20];
  assign funct7 = fetch.instr[31:25];

  assign alu_op = (opcode == OPC_RTYPE) ? decode_alu_op(funct7, funct3) : ALU_NOP;
  assign wb_en  = (alu_op != ALU_NOP);

  riscv_rtype_reg_file #(.XLEN(XLEN)) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .wr_en    (wb_en),
    .wr_addr  (rd),
    .wr_data  (wb_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

endmodule

// File: rtl/riscv_rtype_if_stage.sv
// Fetch stage: program counter plus the word-addressed instruction ROM.
module riscv_rtype_imem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [31:0]              instr
);

  logic [31:0] mem [0:DEPTH-1];

  // Load port is tied off in this core; contents are preloaded from outside.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign instr = mem[addr];

endmodule

module riscv_rtype_if_stage #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  riscv_rtype_if.master   fetch
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  assign pc_next = pc_reg + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= '0;
    else      pc_reg <= pc_next;
  end

  // Dropping the upper PC bits makes the fetch index wrap modulo IMEM_DEPTH.
  riscv_rtype_imem #(.DEPTH(IMEM_DEPTH)) u_imem (
    .clk     (clk),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_data ('0),
    .addr    (pc_reg[AW+1:2]),
    .instr   (fetch.instr)
  );

endmodule

// File: rtl/riscv_rtype_top.sv
// Single-cycle RV32I core that executes only R-type ALU instructions.
module riscv_rtype_top
  import riscv_rtype_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int XLEN       = 32
) (
  input  logic clk,
  input  logic rst
);

  riscv_rtype_if fetch_bus ();

  alu_op_t         alu_op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_result;

  riscv_rtype_if_stage #(.IMEM_DEPTH(IMEM_DEPTH)) u_if_stage (
    .clk   (clk),
    .rst   (rst),
    .fetch (fetch_bus.master)
  );

  riscv_rtype_id_stage #(.XLEN(XLEN)) u_id_stage (
    .clk      (clk),
    .rst      (rst),
    .fetch    (fetch_bus.slave),
    .wb_data  (alu_result),
    .alu_op   (alu_op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  riscv_rtype_alu #(.XLEN(XLEN)) u_alu (
    .op (alu_op),
    .a  (rs1_data),
    .b  (rs2_data),
    .y  (alu_result)
  );

endmodule

// File: tb/tb_riscv_rtype_top.sv
// Directed bench: program preloaded through hierarchy, per-instruction scoreboard of register effects.
`timescale 1ns/1ps
module tb_riscv_rtype_top;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    string       tag;
  } exp_t;

  localparam int NPROG = 15;
  localparam logic [31:0] NOP_WORD = 32'h00000013;

  localparam logic [31:0] PROG [0:NPROG-1] = '{
    32'h002081B3, 32'h40208233, 32'h0020F2B3, 32'h0020E333, 32'h0020C3B3,
    32'h0020A433, 32'h401254B3, 32'h00125533, 32'h00208033, 32'h00000013,
    32'h402095B3, 32'h00209633, 32'h0040B6B3, 32'h00122733, 32'h00210133
  };
  // rd 0 marks "no architectural change" (x0 target, non-R-type, unsupported funct pair).
  localparam logic [4:0] EXP_RD [0:NPROG-1] = '{
    5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd0, 5'd0, 5'd0, 5'd12, 5'd13, 5'd14, 5'd2
  };
  localparam logic [31:0] EXP_VAL [0:NPROG-1] = '{
    32'd12, 32'hFFFFFFFE, 32'd5, 32'd7, 32'd2, 32'd1, 32'hFFFFFFFF, 32'h07FFFFFF,
    32'd0, 32'd0, 32'd0, 32'h00000280, 32'd1, 32'd1, 32'd14
  };

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  exp_t sb [$];
  logic [31:0] exp_regs [0:31];

  riscv_rtype_if obs_if ();

  riscv_rtype_top #(.IMEM_DEPTH(256), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst)
  );

  assign obs_if.instr = dut.u_if_stage.u_imem.instr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) dut.u_if_stage.u_imem.mem[i] = NOP_WORD;
    for (int i = 0; i < NPROG; i++) begin
      dut.u_if_stage.u_imem.mem[i] = PROG[i];
      sb.push_back('{rd: EXP_RD[i], val: EXP_VAL[i], tag: $sformatf("mem[%0d]", i)});
    end
  endtask

  task automatic preload_regs();
    dut.u_id_stage.u_reg_file.regfile[1] = 32'd5;
    dut.u_id_stage.u_reg_file.regfile[2] = 32'd7;
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
    exp_regs[1] = 32'd5;
    exp_regs[2] = 32'd7;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " pc"}, dut.u_if_stage.pc_reg, 32'd0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s x%0d", tag, i), dut.u_id_stage.u_reg_file.regfile[i], 32'd0);
  endtask

  task automatic one_cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk($sformatf("pc cyc%0d", cyc), dut.u_if_stage.pc_reg, 32'(cyc * 4));
  endtask

  task automatic run_steps(input int n);
    exp_t e;
    logic [31:0] exp_instr;
    for (int s = 0; s < n; s++) begin
      one_cycle();
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("FAIL scoreboard: got empty queue expected entry at cyc %0d", cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.rd != 5'd0) exp_regs[e.rd] = e.val;
        for (int r = 0; r < 32; r++)
          chk($sformatf("%s x%0d", e.tag, r), dut.u_id_stage.u_reg_file.regfile[r], exp_regs[r]);
        exp_instr = (cyc < NPROG) ? PROG[cyc] : NOP_WORD;
        chk($sformatf("%s next instr", e.tag), obs_if.instr, exp_instr);
        $display("[TB] cyc %0d %s rd=x%0d val=%h pc=%h", cyc, e.tag, e.rd, e.val,
                 dut.u_if_stage.pc_reg);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b0;
    load_program();

    #7;
    check_all_zero("reset");
    #3;
    rst = 1'b1;
    preload_regs();
    run_steps(NPROG);

    repeat (20 - NPROG) one_cycle();

    // Asynchronous assert mid-cycle: state must clear without waiting for an edge.
    rst = 1'b0;
    #1;
    check_all_zero("midrun reset");
    $display("[TB] mid-run reset applied after %0d cycles", cyc);
    load_program();
    @(posedge clk);
    @(negedge clk);
    chk("pc held in reset", dut.u_if_stage.pc_reg, 32'd0);
    rst = 1'b1;
    cyc = 0;
    preload_regs();
    run_steps(NPROG);

    // Run past the end of the 256-word ROM so mem[0..14] executes a second time.
    while (cyc < 256 + NPROG) one_cycle();
    $display("[TB] wrap run finished at cyc %0d pc=%h", cyc, dut.u_if_stage.pc_reg);
    chk("wrap pc", dut.u_if_stage.pc_reg, 32'h0000043C);
    chk("wrap x3", dut.u_id_stage.u_reg_file.regfile[3], 32'd19);
    chk("wrap x4", dut.u_id_stage.u_reg_file.regfile[4], 32'hFFFFFFF7);
    chk("wrap x12", dut.u_id_stage.u_reg_file.regfile[12], 32'h00014000);
    chk("wrap x2", dut.u_id_stage.u_reg_file.regfile[2], 32'd28);
    chk("wrap x11", dut.u_id_stage.u_reg_file.regfile[11], 32'd0);
    chk("wrap x0", dut.u_id_stage.u_reg_file.regfile[0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
